ift_mmio_responder: RTL and testbench

//  Taint-tracking MMIO responder: the device end of the core's MMIO request interface (req/we/addr/wdata/strb -> rdata),

---
 rtl/ift_mmio_responder_if.sv | 35 +++
 rtl/ift_mmio_responder.sv | 210 +++++++++++++++++++++
 tb/tb_ift_mmio_responder.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ift_mmio_responder_if.sv
// MMIO request/response bus with a bit-exact taint shadow on every signal.
// The core side drives requests (master); the device side returns read data (slave).
interface ift_mmio_responder_if #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic                 mmio_req_i;
  logic                 mmio_req_i_t0;
  logic                 mmio_we_i;
  logic                 mmio_we_i_t0;
  logic [AddrWidth-1:0] mmio_addr_i;
  logic [AddrWidth-1:0] mmio_addr_i_t0;
  logic [DataWidth-1:0] mmio_wdata_i;
  logic [DataWidth-1:0] mmio_wdata_i_t0;
  logic [StrbWidth-1:0] mmio_strb_i;
  logic [StrbWidth-1:0] mmio_strb_i_t0;
  logic [DataWidth-1:0] mmio_rdata_o;
  logic [DataWidth-1:0] mmio_rdata_o_t0;

  modport master (
    output mmio_req_i, mmio_req_i_t0, mmio_we_i, mmio_we_i_t0,
    output mmio_addr_i, mmio_addr_i_t0, mmio_wdata_i, mmio_wdata_i_t0,
    output mmio_strb_i, mmio_strb_i_t0,
    input  mmio_rdata_o, mmio_rdata_o_t0
  );

  modport slave (
    input  mmio_req_i, mmio_req_i_t0, mmio_we_i, mmio_we_i_t0,
    input  mmio_addr_i, mmio_addr_i_t0, mmio_wdata_i, mmio_wdata_i_t0,
    input  mmio_strb_i, mmio_strb_i_t0,
    output mmio_rdata_o, mmio_rdata_o_t0
  );
endinterface

// File: rtl/ift_mmio_responder.sv
// Taint-tracking MMIO responder: STOP/SCRATCH/TX-FIFO/STATUS/CYCLE registers, each stored bit shadowed by a taint bit.
// Read data is registered (1-cycle latency); IFT_MMIO_CTRL_TAINT_EN enables control-taint propagation.
module ift_mmio_responder #(
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          DataWidth = 64,
  parameter logic [AddrWidth-1:0] BaseAddr  = AddrWidth'(32'h1000_0000),
  parameter int unsigned          FifoDepth = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  ift_mmio_responder_if.slave       mmio,
  output logic                      stop_o,
  output logic                      stop_o_t0,
  output logic                      tx_valid_o,
  input  logic                      tx_ready_i,
  output logic [7:0]                tx_data_o,
  output logic [7:0]                tx_data_o_t0,
  output logic                      decode_err_o
);
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned PtrW      = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW      = PtrW + 1;
  localparam logic [AddrWidth-1:0] WinBytes = AddrWidth'(40);

  localparam logic [2:0] RegStop    = 3'd0;
  localparam logic [2:0] RegScratch = 3'd1;
  localparam logic [2:0] RegTx      = 3'd2;
  localparam logic [2:0] RegStatus  = 3'd3;
  localparam logic [2:0] RegCycle   = 3'd4;

  logic [DataWidth-1:0] stop_q, stop_d, stop_t0_q, stop_t0_d;
  logic [DataWidth-1:0] scratch_q, scratch_d, scratch_t0_q, scratch_t0_d;
  logic [DataWidth-1:0] rdata_q, rdata_d, rdata_t0_q, rdata_t0_d;
  logic [63:0]          cycle_q, cycle_d;
  logic                 ovf_q, ovf_d;
  logic                 decode_err_q, decode_err_d;
  logic [7:0]           fifo_dat_q [FifoDepth];
  logic [7:0]           fifo_dat_d [FifoDepth];
  logic [7:0]           fifo_t0_q  [FifoDepth];
  logic [7:0]           fifo_t0_d  [FifoDepth];
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]      count_q, count_d;

  logic [AddrWidth-1:0] offset;
  logic [2:0]           sel;
  logic                 in_window, aligned, hit, wr_en, rd_req;
  logic                 ctrl_t;
  logic [StrbWidth-1:0] force_t0;
  logic                 full, pop, tx_wr, push;
  logic [DataWidth-1:0] status_val;

`ifdef IFT_MMIO_CTRL_TAINT_EN
  assign ctrl_t   = mmio.mmio_req_i_t0 | mmio.mmio_we_i_t0 | (|mmio.mmio_addr_i_t0);
  assign force_t0 = mmio.mmio_strb_i_t0 | {StrbWidth{ctrl_t}};
`else
  logic ctrl_t0_unused;
  assign ctrl_t0_unused = ^{mmio.mmio_req_i_t0, mmio.mmio_we_i_t0, mmio.mmio_addr_i_t0, mmio.mmio_strb_i_t0};
  assign ctrl_t   = 1'b0;
  assign force_t0 = '0;
`endif

  function automatic logic [DataWidth-1:0] merge_dat(input logic [DataWidth-1:0] old_v,
                                                     input logic [DataWidth-1:0] new_v,
                                                     input logic [StrbWidth-1:0] strb);
    logic [DataWidth-1:0] r;
    r = old_v;
    for (int i = 0; i < StrbWidth; i++) begin
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  // Forced bytes become fully tainted even when their data byte is not written.
  function automatic logic [DataWidth-1:0] merge_t0(input logic [DataWidth-1:0] old_t,
                                                    input logic [DataWidth-1:0] new_t,
                                                    input logic [StrbWidth-1:0] strb,
                                                    input logic [StrbWidth-1:0] frc);
    logic [DataWidth-1:0] r;
    r = old_t;
    for (int i = 0; i < StrbWidth; i++) begin
      if (strb[i]) r[8*i +: 8] = new_t[8*i +: 8];
      if (frc[i])  r[8*i +: 8] = 8'hFF;
    end
    return r;
  endfunction

  assign offset    = mmio.mmio_addr_i - BaseAddr;
  assign in_window = offset < WinBytes;
  assign aligned   = mmio.mmio_addr_i[2:0] == 3'b000;
  assign sel       = offset[5:3];
  assign hit       = mmio.mmio_req_i & in_window & aligned;
  assign wr_en     = hit & mmio.mmio_we_i;
  assign rd_req    = mmio.mmio_req_i & ~mmio.mmio_we_i;

  assign full      = count_q == CntW'(FifoDepth);
  assign pop       = tx_valid_o & tx_ready_i;
  assign tx_wr     = wr_en & (sel == RegTx) & mmio.mmio_strb_i[0];
  assign push      = tx_wr & (~full | pop);

  assign status_val = {{(DataWidth-16){1'b0}}, 8'(count_q), 6'b0, ovf_q, stop_q[0]};

  always_comb begin
    stop_d       = stop_q;
    stop_t0_d    = stop_t0_q;
    scratch_d    = scratch_q;
    scratch_t0_d = scratch_t0_q;
    rdata_d      = rdata_q;
    rdata_t0_d   = rdata_t0_q;
    ovf_d        = ovf_q;
    fifo_dat_d   = fifo_dat_q;
    fifo_t0_d    = fifo_t0_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cycle_d      = cycle_q + 64'd1;
    decode_err_d = mmio.mmio_req_i & ~(in_window & aligned);
    count_d      = count_q + CntW'(push) - CntW'(pop);

    if (wr_en) begin
      case (sel)
        RegStop: begin
          stop_d    = merge_dat(stop_q, mmio.mmio_wdata_i, mmio.mmio_strb_i);
          stop_t0_d = merge_t0(stop_t0_q, mmio.mmio_wdata_i_t0, mmio.mmio_strb_i, force_t0);
        end
        RegScratch: begin
          scratch_d    = merge_dat(scratch_q, mmio.mmio_wdata_i, mmio.mmio_strb_i);
          scratch_t0_d = merge_t0(scratch_t0_q, mmio.mmio_wdata_i_t0, mmio.mmio_strb_i, force_t0);
        end
        default: ;
      endcase
    end

    // A full FIFO still accepts a push when the consumer pops in the same cycle.
    if (tx_wr & full & ~pop) ovf_d = 1'b1;
    if (push) begin
      fifo_dat_d[wptr_q] = mmio.mmio_wdata_i[7:0];
      fifo_t0_d[wptr_q]  = mmio.mmio_wdata_i_t0[7:0] | {8{force_t0[0]}};
      wptr_d             = wptr_q + PtrW'(1);
    end
    if (pop) rptr_d = rptr_q + PtrW'(1);

    if (rd_req) begin
      rdata_d    = '0;
      rdata_t0_d = '0;
      if (hit) begin
        case (sel)
          RegStop: begin
            rdata_d    = stop_q;
            rdata_t0_d = stop_t0_q;
          end
          RegScratch: begin
            rdata_d    = scratch_q;
            rdata_t0_d = scratch_t0_q;
          end
          RegStatus: begin
            rdata_d    = status_val;
            rdata_t0_d = {{(DataWidth-1){1'b0}}, stop_t0_q[0]};
          end
          RegCycle:  rdata_d = DataWidth'(cycle_q);
          default: ;
        endcase
      end
      if (ctrl_t) rdata_t0_d = '1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stop_q       <= '0;
      stop_t0_q    <= '0;
      scratch_q    <= '0;
      scratch_t0_q <= '0;
      rdata_q      <= '0;
      rdata_t0_q   <= '0;
      cycle_q      <= '0;
      ovf_q        <= 1'b0;
      decode_err_q <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_dat_q[i] <= '0;
        fifo_t0_q[i]  <= '0;
      end
    end else begin
      stop_q       <= stop_d;
      stop_t0_q    <= stop_t0_d;
      scratch_q    <= scratch_d;
      scratch_t0_q <= scratch_t0_d;
      rdata_q      <= rdata_d;
      rdata_t0_q   <= rdata_t0_d;
      cycle_q      <= cycle_d;
      ovf_q        <= ovf_d;
      decode_err_q <= decode_err_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
      fifo_dat_q   <= fifo_dat_d;
      fifo_t0_q    <= fifo_t0_d;
    end
  end

  assign mmio.mmio_rdata_o    = rdata_q;
  assign mmio.mmio_rdata_o_t0 = rdata_t0_q;
  assign stop_o               = stop_q[0];
  assign stop_o_t0            = stop_t0_q[0];
  assign tx_valid_o           = count_q != '0;
  assign tx_data_o            = fifo_dat_q[rptr_q];
  assign tx_data_o_t0         = fifo_t0_q[rptr_q];
  assign decode_err_o         = decode_err_q;
endmodule

// File: tb/tb_ift_mmio_responder.sv
// Scoreboard bench for ift_mmio_responder: expected read responses and TX bytes are queued at stimulus time.
module tb_ift_mmio_responder;
  localparam logic [31:0] Base = 32'h1000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx_ready = 1'b0;
  logic stop_o, stop_o_t0, tx_valid_o, decode_err_o;
  logic [7:0] tx_data_o, tx_data_o_t0;

  int checks = 0;
  int errors = 0;

  logic [127:0] exp_q[$];
  logic [127:0] obs_q[$];
  logic [15:0]  exp_tx_q[$];
  logic [63:0]  model_cyc;
  logic         rd_seen;

  ift_mmio_responder_if #(.AddrWidth(32), .DataWidth(64)) bus ();

  ift_mmio_responder #(.AddrWidth(32), .DataWidth(64), .BaseAddr(Base), .FifoDepth(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .mmio         (bus),
    .stop_o       (stop_o),
    .stop_o_t0    (stop_o_t0),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready),
    .tx_data_o    (tx_data_o),
    .tx_data_o_t0 (tx_data_o_t0),
    .decode_err_o (decode_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_cyc <= '0;
    else        model_cyc <= model_cyc + 64'd1;
  end

  always @(posedge clk) rd_seen <= rst_n & bus.mmio_req_i & ~bus.mmio_we_i;
  always @(negedge clk) if (rd_seen) obs_q.push_back({bus.mmio_rdata_o, bus.mmio_rdata_o_t0});

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic bus_idle();
    bus.mmio_req_i = 1'b0; bus.mmio_req_i_t0 = 1'b0;
    bus.mmio_we_i = 1'b0;  bus.mmio_we_i_t0 = 1'b0;
    bus.mmio_addr_i = '0;  bus.mmio_addr_i_t0 = '0;
    bus.mmio_wdata_i = '0; bus.mmio_wdata_i_t0 = '0;
    bus.mmio_strb_i = '0;  bus.mmio_strb_i_t0 = '0;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus_idle();
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [63:0] wd,
                       input logic [7:0] strb, input logic [63:0] wt0, input logic [31:0] at0,
                       input logic [7:0] st0);
    @(negedge clk);
    bus_idle();
    bus.mmio_req_i = 1'b1;
    bus.mmio_we_i = we;
    bus.mmio_addr_i = addr;
    bus.mmio_addr_i_t0 = at0;
    bus.mmio_wdata_i = wd;
    bus.mmio_wdata_i_t0 = wt0;
    bus.mmio_strb_i = strb;
    bus.mmio_strb_i_t0 = st0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] strb, input logic [63:0] wt0);
    drive(1'b1, addr, wd, strb, wt0, 32'h0, 8'h0);
  endtask

  task automatic rd(input logic [31:0] addr, input logic [63:0] ed, input logic [63:0] et);
    drive(1'b0, addr, 64'h0, 8'h0, 64'h0, 32'h0, 8'h0);
    exp_q.push_back({ed, et});
  endtask

  task automatic do_reset();
    bus_idle();
    tx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete(); exp_tx_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({stop_o, stop_o_t0, tx_valid_o, tx_data_o, tx_data_o_t0} !== 19'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {stop_o, stop_o_t0, tx_valid_o, tx_data_o, tx_data_o_t0});
    end
    checks++;
    if (decode_err_o !== 1'b0) begin errors++; $display("FAIL reset_decode_err got %b want 0", decode_err_o); end
    checks++;
    if ({bus.mmio_rdata_o, bus.mmio_rdata_o_t0} !== 128'h0) begin
      errors++; $display("FAIL reset_rdata got %h_%h want 0", bus.mmio_rdata_o, bus.mmio_rdata_o_t0);
    end
  endtask

  task automatic test_scratch();
    logic [127:0] e, o;
    do_reset();
    wr(Base + 32'h8, 64'hDEAD_BEEF_0123_4567, 8'hFF, 64'h0);
    rd(Base + 32'h8, 64'hDEAD_BEEF_0123_4567, 64'h0);
    wr(Base + 32'h8, 64'h1111_1111_2222_2222, 8'h0F, 64'hFF);
    rd(Base + 32'h8, 64'hDEAD_BEEF_2222_2222, 64'hFF);
    drive(1'b1, Base + 32'h8, 64'h0, 8'h00, 64'h0, 32'h0, 8'h01);
`ifdef IFT_MMIO_CTRL_TAINT_EN
    rd(Base + 32'h8, 64'hDEAD_BEEF_2222_2222, 64'hFF);
`else
    rd(Base + 32'h8, 64'hDEAD_BEEF_2222_2222, 64'hFF);
`endif
    wr(Base + 32'h18, 64'hFFFF, 8'hFF, 64'hFFFF);
    rd(Base + 32'h18, 64'h0, 64'h0);
    idle(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL scratch_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL scratch_read got %h_%h want %h_%h", o[127:64], o[63:0], e[127:64], e[63:0]); end
    end
  endtask

  task automatic test_tx_fifo();
    logic [127:0] e, o;
    logic [15:0] et;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      wr(Base + 32'h10, {56'hA5A5_0000_0000_00, 8'(i)}, 8'h01, {56'h0, 8'(i) ^ 8'h5A});
      if (i <= 8) exp_tx_q.push_back({8'(i), 8'(i) ^ 8'h5A});
    end
    wr(Base + 32'h10, 64'h77, 8'h02, 64'h0);
    rd(Base + 32'h10, 64'h0, 64'h0);
    rd(Base + 32'h18, 64'h0802, 64'h0);
    idle(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL tx_status_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL tx_status got %h_%h want %h_%h", o[127:64], o[63:0], e[127:64], e[63:0]); end
    end
    tx_ready = 1'b1;
    for (int c = 0; c < 20 && tx_valid_o; c++) begin
      checks++;
      if (exp_tx_q.size() == 0) begin
        errors++; $display("FAIL tx_drain_extra got %h want none", {tx_data_o, tx_data_o_t0});
      end else begin
        et = exp_tx_q.pop_front();
        if ({tx_data_o, tx_data_o_t0} !== et) begin
          errors++; $display("FAIL tx_drain got %h want %h", {tx_data_o, tx_data_o_t0}, et);
        end
      end
      @(negedge clk);
    end
    tx_ready = 1'b0;
    checks++;
    if (exp_tx_q.size() != 0 || tx_valid_o !== 1'b0) begin
      errors++; $display("FAIL tx_drain_end got left=%0d valid=%b want left=0 valid=0", exp_tx_q.size(), tx_valid_o);
    end
    rd(Base + 32'h18, 64'h0002, 64'h0);
    idle(3);
    e = exp_q.pop_front(); checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL tx_ovf_sticky got %0d responses want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL tx_ovf_sticky got %h want %h", o, e); end
    end
  endtask

  task automatic test_full_push_pop();
    logic [127:0] e, o;
    do_reset();
    for (int i = 0; i < 8; i++) wr(Base + 32'h10, 64'(i), 8'h01, 64'h0);
    wr(Base + 32'h10, 64'h99, 8'h01, 64'h0);
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;
    rd(Base + 32'h18, 64'h0800, 64'h0);
    idle(3);
    e = exp_q.pop_front(); checks++;
    if (obs_q.size() != 1) begin
      errors++; $display("FAIL full_push_pop got %0d responses want 1", obs_q.size());
    end else begin
      o = obs_q.pop_front();
      if (o !== e) begin errors++; $display("FAIL full_push_pop got %h want %h", o, e); end
    end
  endtask

  task automatic test_stop_decode();
    logic [127:0] e, o;
    do_reset();
    wr(Base, 64'h1, 8'h01, 64'h1);
    @(posedge clk); #1;
    checks++;
    if ({stop_o, stop_o_t0} !== 2'b11) begin errors++; $display("FAIL stop_out got %b want 11", {stop_o, stop_o_t0}); end
    rd(Base, 64'h1, 64'h1);
    rd(Base + 32'h18, 64'h1, 64'h1);
    rd(Base + 32'h40, 64'h0, 64'h0);
    @(posedge clk); #1;
    checks++;
    if (decode_err_o !== 1'b1) begin errors++; $display("FAIL decode_err_window got %b want 1", decode_err_o); end
    rd(Base + 32'h8, 64'h0, 64'h0);
    @(posedge clk); #1;
    checks++;
    if (decode_err_o !== 1'b0) begin errors++; $display("FAIL decode_err_valid got %b want 0", decode_err_o); end
    rd(Base + 32'hC, 64'h0, 64'h0);
    @(posedge clk); #1;
    checks++;
    if (decode_err_o !== 1'b1) begin errors++; $display("FAIL decode_err_align got %b want 1", decode_err_o); end
    wr(Base + 32'h44, 64'h0, 8'h01, 64'h0);
    idle(1);
    @(posedge clk); #1;
    checks++;
    if (decode_err_o !== 1'b0) begin errors++; $display("FAIL decode_err_pulse got %b want 0", decode_err_o); end
    rd(Base, 64'h1, 64'h1);
    idle(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL stop_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL stop_read got %h_%h want %h_%h", o[127:64], o[63:0], e[127:64], e[63:0]); end
    end
  endtask

  task automatic test_cycle_ctrl();
    logic [127:0] e, o;
    logic [63:0] ctl_t;
`ifdef IFT_MMIO_CTRL_TAINT_EN
    ctl_t = '1;
`else
    ctl_t = '0;
`endif
    do_reset();
    idle(5);
    drive(1'b0, Base + 32'h20, 64'h0, 8'h0, 64'h0, 32'h0, 8'h0);
    exp_q.push_back({model_cyc, 64'h0});
    drive(1'b0, Base + 32'h20, 64'h0, 8'h0, 64'h0, 32'h8, 8'h0);
    exp_q.push_back({model_cyc, ctl_t});
    idle(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL cycle_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL cycle_read got %h_%h want %h_%h", o[127:64], o[63:0], e[127:64], e[63:0]); end
    end
  endtask

  task automatic test_async_reset();
    logic [127:0] e, o;
    do_reset();
    for (int i = 1; i <= 3; i++) wr(Base + 32'h10, 64'(i), 8'h01, 64'h0);
    wr(Base, 64'h1, 8'h01, 64'h0);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL async_tx_valid got %b want 0", tx_valid_o); end
    checks++;
    if (stop_o !== 1'b0) begin errors++; $display("FAIL async_stop got %b want 0", stop_o); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, Base + 32'h20, 64'h0, 8'h0, 64'h0, 32'h0, 8'h0);
    exp_q.push_back({model_cyc, 64'h0});
    rd(Base + 32'h18, 64'h0, 64'h0);
    idle(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL async_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL async_read got %h_%h want %h_%h", o[127:64], o[63:0], e[127:64], e[63:0]); end
    end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_scratch();
    test_tx_fifo();
    test_full_push_pop();
    test_stop_decode();
    test_cycle_ctrl();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
